vending_controller: RTL and testbench

Sequential controller for the vending-machine datapath. It accumulates inserted credit and tracks per-product stock. On a buy request it checks credit against the selected product's price, drives the dispense indication for a fixed number of cycles, and issues the change amount. It sits between the board inputs (coin/select/buy switches, debounced upstream into one-cycle pulses) and the existing price-mux, subtractor and seven-segment display logic. It replaces the purely combinational purchase decision with a registered, stock-aware flow.

---
 rtl/vending_controller.sv | 188 ++++++++++++++++++
 tb/tb_vending_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_controller.sv
// Registered, stock-aware vending controller: accumulates credit, arbitrates
// coin/buy/cancel/refill events, holds vend for DISP_CYCLES, then strobes change.

module vending_stock_slot #(
    parameter logic [3:0] STOCK_INIT = 4'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic dec,
    output logic empty
);
    logic [3:0] stock;

    // empty is kept in lockstep with the counter so it is a registered flag
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            stock <= STOCK_INIT;
            empty <= (STOCK_INIT == 4'd0);
        end else if (dec && stock != 4'd0) begin
            stock <= stock - 4'd1;
            empty <= (stock == 4'd1);
        end
    end
endmodule

module vending_controller #(
    parameter logic [4:0] PRICE0      = 5'd1,
    parameter logic [4:0] PRICE1      = 5'd3,
    parameter logic [4:0] PRICE2      = 5'd5,
    parameter logic [4:0] PRICE3      = 5'd10,
    parameter logic [3:0] STOCK_INIT  = 4'd4,
    parameter int         DISP_CYCLES = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [4:0] coin_val,
    input  logic [1:0] sel,
    input  logic       buy,
    input  logic       cancel,
    input  logic       refill,
    output logic [4:0] credit,
    output logic [4:0] price,
    output logic [3:0] vend,
    output logic [4:0] change,
    output logic       change_valid,
    output logic       deny,
    output logic       coin_reject,
    output logic [3:0] empty,
    output logic       busy
);
    localparam logic [7:0] DISP_LD = 8'(DISP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_PAYOUT,
        S_DENY
    } state_t;

    state_t     state, state_n;
    logic [4:0] credit_n, change_n;
    logic [3:0] vend_n;
    logic [7:0] cnt, cnt_n;
    logic       change_valid_n, deny_n, coin_reject_n, busy_n;
    logic [3:0] stock_dec;
    logic       stock_reload;
    logic [5:0] coin_sum;

    always_comb begin
        case (sel)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            default: price = PRICE3;
        endcase
    end

    assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_slot
            vending_stock_slot #(.STOCK_INIT(STOCK_INIT)) u_slot (
                .clk    (CLOCK_50),
                .reset  (reset),
                .reload (stock_reload),
                .dec    (stock_dec[i]),
                .empty  (empty[i])
            );
        end
    endgenerate

    always_comb begin
        state_n       = state;
        credit_n      = credit;
        change_n      = change;
        vend_n        = vend;
        cnt_n         = cnt;
        coin_reject_n = 1'b0;
        stock_dec     = 4'b0000;
        stock_reload  = 1'b0;

        case (state)
            S_IDLE, S_CREDIT: begin
                // cancel > refill > buy > coin; a coin beaten by any of them bounces
                if (cancel) begin
                    coin_reject_n = coin_valid;
                    if (state == S_CREDIT) begin
                        change_n = credit;
                        credit_n = 5'd0;
                        state_n  = S_PAYOUT;
                    end
                end else if (refill) begin
                    coin_reject_n = coin_valid;
                    stock_reload  = 1'b1;
                end else if (buy) begin
                    coin_reject_n = coin_valid;
                    if (empty[sel] || credit < price) begin
                        state_n = S_DENY;
                    end else begin
                        stock_dec[sel] = 1'b1;
                        change_n       = credit - price;
                        credit_n       = 5'd0;
                        vend_n         = 4'b0001 << sel;
                        cnt_n          = DISP_LD;
                        state_n        = S_VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= 6'd31) begin
                        credit_n = coin_sum[4:0];
                        state_n  = (coin_sum == 6'd0) ? S_IDLE : S_CREDIT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_n = coin_valid;
                if (cnt <= 8'd1) begin
                    vend_n  = 4'b0000;
                    state_n = S_PAYOUT;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_PAYOUT: begin
                coin_reject_n = coin_valid;
                state_n       = S_IDLE;
            end
            S_DENY: begin
                coin_reject_n = coin_valid;
                state_n       = (credit == 5'd0) ? S_IDLE : S_CREDIT;
            end
            default: state_n = S_IDLE;
        endcase

        change_valid_n = (state_n == S_PAYOUT);
        deny_n         = (state_n == S_DENY);
        busy_n         = change_valid_n || deny_n || (state_n == S_VEND);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= S_IDLE;
            credit       <= 5'd0;
            change       <= 5'd0;
            change_valid <= 1'b0;
            vend         <= 4'b0000;
            deny         <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
            cnt          <= 8'd0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            change       <= change_n;
            change_valid <= change_valid_n;
            vend         <= vend_n;
            deny         <= deny_n;
            coin_reject  <= coin_reject_n;
            busy         <= busy_n;
            cnt          <= cnt_n;
        end
    end
endmodule

// File: tb/tb_vending_controller.sv
// Directed + random bench for vending_controller; a timestamp-based model
// predicts every output cycle by cycle from the purchase rules.

module tb_vending_controller;
    localparam int D     = 8;
    localparam int SINIT = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1, coin_valid = 1'b0, buy = 1'b0, cancel = 1'b0, refill = 1'b0;
    logic [4:0] coin_val = 5'd0;
    logic [1:0] sel = 2'd0;
    logic [4:0] credit, price, change;
    logic [3:0] vend, empty;
    logic       change_valid, deny, coin_reject, busy;

    int n_vec = 0, n_bad = 0;

    // model state: amounts plus the cycle numbers at which pulses are due
    int cyc = 0;
    int m_credit = 0, m_change = 0;
    int m_stock [4] = '{SINIT, SINIT, SINIT, SINIT};
    int vend_prod = 0, vend_start = 0, vend_end = -1;
    int pay_at = -1, deny_at = -1, rej_at = -1, free_at = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    vending_controller dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .sel          (sel),
        .buy          (buy),
        .cancel       (cancel),
        .refill       (refill),
        .credit       (credit),
        .price        (price),
        .vend         (vend),
        .change       (change),
        .change_valid (change_valid),
        .deny         (deny),
        .coin_reject  (coin_reject),
        .empty        (empty),
        .busy         (busy)
    );

    function automatic int price_of(input int s);
        case (s)
            0:       return 1;
            1:       return 3;
            2:       return 5;
            default: return 10;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int p;
        if (reset) begin
            m_credit = 0; m_change = 0;
            for (int k = 0; k < 4; k++) m_stock[k] = SINIT;
            vend_end = -1; pay_at = -1; deny_at = -1; rej_at = -1;
            free_at = cyc + 1;
        end else if (cyc < free_at) begin
            if (coin_valid) rej_at = cyc + 1;
        end else if (cancel) begin
            if (coin_valid) rej_at = cyc + 1;
            if (m_credit > 0) begin
                m_change = m_credit; m_credit = 0;
                pay_at = cyc + 1; free_at = cyc + 2;
            end
        end else if (refill) begin
            if (coin_valid) rej_at = cyc + 1;
            for (int k = 0; k < 4; k++) m_stock[k] = SINIT;
        end else if (buy) begin
            if (coin_valid) rej_at = cyc + 1;
            p = price_of(int'(sel));
            if (m_stock[sel] == 0 || m_credit < p) begin
                deny_at = cyc + 1; free_at = cyc + 2;
            end else begin
                m_stock[sel]--;
                m_change = m_credit - p; m_credit = 0;
                vend_prod = int'(sel);
                vend_start = cyc + 1; vend_end = cyc + D;
                pay_at = cyc + D + 1; free_at = cyc + D + 2;
            end
        end else if (coin_valid) begin
            if (m_credit + int'(coin_val) <= 31) m_credit += int'(coin_val);
            else rej_at = cyc + 1;
        end
        cyc++;
    endtask

    task automatic check_all();
        logic [3:0] ev, ee;
        ev = (cyc >= vend_start && cyc <= vend_end) ? 4'(1 << vend_prod) : 4'b0000;
        for (int k = 0; k < 4; k++) ee[k] = (m_stock[k] == 0);
        check("credit", 8'(credit), 8'(m_credit));
        check("vend", 8'(vend), 8'(ev));
        check("change", 8'(change), 8'(m_change));
        check("change_valid", 8'(change_valid), 8'(cyc == pay_at));
        check("deny", 8'(deny), 8'(cyc == deny_at));
        check("coin_reject", 8'(coin_reject), 8'(cyc == rej_at));
        check("busy", 8'(busy), 8'(cyc < free_at));
        check("empty", 8'(empty), 8'(ee));
    endtask

    task automatic step(input logic r, input logic cv, input logic [4:0] cval,
                        input logic [1:0] s, input logic b, input logic c, input logic rf);
        @(negedge CLOCK_50);
        reset = r; coin_valid = cv; coin_val = cval; sel = s; buy = b; cancel = c; refill = rf;
        #1 check("price", 8'(price), 8'(price_of(int'(s))));
        @(posedge CLOCK_50);
        model_edge();
        #1 check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic coin(input logic [4:0] v);
        step(1'b0, 1'b1, v, sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_buy(input logic [1:0] s);
        step(1'b0, 1'b0, 5'd0, s, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic r, cv, b, c, rf;
        logic [4:0] cval;
        logic [1:0] s;

        step(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("rst_empty", 8'(empty), 8'd0);

        // coins 2 + 3, buy product 2 for exact change
        coin(5'd2); coin(5'd3);
        check("credit5", 8'(credit), 8'd5);
        do_buy(2'd2);
        check("vend_p2", 8'(vend), 8'b0100);
        idle(D + 2);

        // insufficient credit -> deny, then cancel refunds
        coin(5'd4); do_buy(2'd3);
        check("deny_credit", 8'(credit), 8'd4);
        idle(1);
        step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("cancel_change", 8'(change), 8'd4);
        idle(1);

        // overflow coin rejected, exact fill to 31 accepted
        coin(5'd10); coin(5'd10); coin(5'd10); coin(5'd5); coin(5'd1);
        check("credit31", 8'(credit), 8'd31);

        // drain product 0: four sales, fifth denied, then refill
        for (int k = 0; k < 5; k++) begin
            if (k > 0) coin(5'd31);
            do_buy(2'd0);
            idle(D + 2);
        end
        check("empty0", 8'(empty), 8'b0001);
        step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("refilled", 8'(empty), 8'd0);

        // cancel beats buy and coin in the same cycle
        coin(5'd6);
        step(1'b0, 1'b1, 5'd2, 2'd0, 1'b1, 1'b1, 1'b0);
        check("prio_change", 8'(change), 8'd6);
        check("prio_reject", 8'(coin_reject), 8'd1);
        idle(2);

        // reset during the 3rd vend cycle
        coin(5'd5); do_buy(2'd2); idle(2);
        step(1'b1, 1'b0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        check("rst_vend", 8'(vend), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        idle(2);

        for (int k = 0; k < 600; k++) begin
            r    = ($urandom_range(63) == 0);
            cv   = ($urandom_range(2) == 0);
            cval = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(6));
            s    = 2'($urandom_range(3));
            b    = ($urandom_range(5) == 0);
            c    = ($urandom_range(11) == 0);
            rf   = ($urandom_range(19) == 0);
            step(r, cv, cval, s, b, c, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
